accum_cpu_controller: RTL and testbench

//  Synthesizable fetch/decode/execute sequencer for the 8-bit accumulator CPU.

---
 rtl/accum_cpu_controller_if.sv | 43 ++++
 rtl/accum_cpu_controller.sv | 216 +++++++++++++++++++++
 tb/tb_accum_cpu_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_cpu_controller_if.sv
// ---------------------------------------------------------------------------
// accum_cpu_controller_if
//   Bundles the sync RAM port and the 8-bit ALU port driven by the
//   accumulator CPU sequencer.
//
//   mem_addr  [7:0]  RAM address
//   mem_wdata [7:0]  RAM write data
//   mem_rdata [7:0]  RAM read data, valid the cycle after a read request
//   mem_cs           RAM chip select
//   mem_we           RAM write enable
//   mem_oe           RAM output enable
//   alu_a     [7:0]  ALU operand A (accumulator)
//   alu_b     [7:0]  ALU operand B (memory buffer)
//   alu_sel   [3:0]  ALU operation select
//   alu_out   [7:0]  combinational ALU result
//
//   master : the sequencer side
//   slave  : the RAM/ALU side
// ---------------------------------------------------------------------------
interface accum_cpu_controller_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_cs;
  logic       mem_we;
  logic       mem_oe;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;

  modport master (
    output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe,
    output alu_a, alu_b, alu_sel,
    input  mem_rdata, alu_out
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe,
    input  alu_a, alu_b, alu_sel,
    output mem_rdata, alu_out
  );
endinterface

// File: rtl/accum_cpu_controller.sv
// ---------------------------------------------------------------------------
// accum_cpu_controller
//   Fetch/decode/execute sequencer for the 8-bit accumulator CPU. Holds PC,
//   IR, MBR and AC, drives a single-port synchronous RAM and an external
//   8-bit ALU. Instructions are two bytes: byte@PC -> IR[15:8] (opcode in
//   IR[15:12]), byte@PC+1 -> IR[7:0] (operand address).
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, start_addr  start pulse (honoured in IDLE/HALT) and initial PC
//   step               single-step advance (only with ACCUM_CPU_SINGLE_STEP_EN)
//   bus                RAM + ALU interface (master modport)
//   pc, ac, ir         architectural state for debug
//   busy, halted       sequencer status
//   fault              halted on an illegal opcode; cleared on start
//
// Build option
//   ACCUM_CPU_SINGLE_STEP_EN : adds the step port and a STEP_WAIT state in
//   front of every instruction fetch. Undefined: free-running.
// ---------------------------------------------------------------------------
module accum_cpu_controller #(
  parameter logic [3:0] ALU_SEL_ADD = 4'b0001,
  parameter logic [3:0] ALU_SEL_SUB = 4'b0010
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    start_addr,
`ifdef ACCUM_CPU_SINGLE_STEP_EN
  input  logic                          step,
`endif
  accum_cpu_controller_if.master        bus,
  output logic [7:0]                    pc,
  output logic [7:0]                    ac,
  output logic [15:0]                   ir,
  output logic                          busy,
  output logic                          halted,
  output logic                          fault
);

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_HALT
`ifdef ACCUM_CPU_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  // Every path that would begin a new instruction enters here; in
  // single-step builds that is the wait state instead of the first fetch.
`ifdef ACCUM_CPU_SINGLE_STEP_EN
  localparam state_t FETCH_ENTRY = S_STEP_WAIT;
`else
  localparam state_t FETCH_ENTRY = S_FETCH1;
`endif

  state_t            state, state_nxt;
  logic [7:0]        mbr;
  logic [3:0]        opcode;
  logic signed [7:0] ac_s;

  // Addresses and PC wrap modulo 256.
  function automatic logic [7:0] addr_add(input logic [7:0] base, input logic [7:0] inc);
    return base + inc;
  endfunction

  // SKIPCOND test on the accumulator interpreted as two's complement.
  function automatic logic skip_taken(input logic [1:0] cond, input logic signed [7:0] acc);
    logic taken;
    case (cond)
      2'b00:   taken = (acc < 8'sd0);
      2'b01:   taken = (acc == 8'sd0);
      2'b10:   taken = (acc > 8'sd0);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic is_mem_read_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUBT);
  endfunction

  assign opcode = ir[15:12];
  assign ac_s   = ac;

  assign bus.alu_a     = ac;
  assign bus.alu_b     = mbr;
  assign bus.alu_sel   = (opcode == OP_SUBT) ? ALU_SEL_SUB : ALU_SEL_ADD;
  assign bus.mem_wdata = ac;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = FETCH_ENTRY;
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: state_nxt = S_FETCH3;
      S_FETCH3: state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT:           state_nxt = S_MEMRD;
          OP_STORE, OP_SKIP, OP_JUMP, OP_CLEAR: state_nxt = FETCH_ENTRY;
          default:                            state_nxt = S_HALT;
        endcase
      end
      S_MEMRD:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = FETCH_ENTRY;
      S_HALT:   if (start) state_nxt = FETCH_ENTRY;
`ifdef ACCUM_CPU_SINGLE_STEP_EN
      S_STEP_WAIT: if (step) state_nxt = S_FETCH1;
`endif
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---- outputs decoded from state ----
  // Memory strobes are purely combinational from state so that an
  // asynchronous reset drops a write in progress immediately.
  always_comb begin
    bus.mem_addr = 8'h00;
    bus.mem_cs   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_oe   = 1'b0;
    busy         = (state != S_IDLE) && (state != S_HALT);
    halted       = (state == S_HALT);
    case (state)
      S_FETCH1: begin
        bus.mem_addr = pc;
        bus.mem_cs   = 1'b1;
        bus.mem_oe   = 1'b1;
      end
      S_FETCH2: begin
        bus.mem_addr = addr_add(pc, 8'd1);
        bus.mem_cs   = 1'b1;
        bus.mem_oe   = 1'b1;
      end
      S_DECODE: begin
        if (is_mem_read_op(opcode)) begin
          bus.mem_addr = ir[7:0];
          bus.mem_cs   = 1'b1;
          bus.mem_oe   = 1'b1;
        end else if (opcode == OP_STORE) begin
          bus.mem_addr = ir[7:0];
          bus.mem_cs   = 1'b1;
          bus.mem_we   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---- architectural registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= 8'h00;
      ac    <= 8'h00;
      mbr   <= 8'h00;
      ir    <= 16'h0000;
      fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= start_addr;
            fault <= 1'b0;
          end
        end
        S_FETCH2: ir[15:8] <= bus.mem_rdata;
        S_FETCH3: begin
          ir[7:0] <= bus.mem_rdata;
          pc      <= addr_add(pc, 8'd2);
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUBT, OP_HALT: ;
            OP_SKIP:  if (skip_taken(ir[11:10], ac_s)) pc <= addr_add(pc, 8'd2);
            OP_JUMP:  pc <= ir[7:0];
            OP_CLEAR: ac <= 8'h00;
            default:  fault <= 1'b1;
          endcase
        end
        S_MEMRD: mbr <= bus.mem_rdata;
        S_EXEC: begin
          if (opcode == OP_LOAD) ac <= mbr;
          else                   ac <= bus.alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu_controller.sv
module tb_accum_cpu_controller;

`ifdef ACCUM_CPU_SINGLE_STEP_EN
  localparam int STEP_EXTRA = 1;
`else
  localparam int STEP_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic        step = 1'b1;
  logic [7:0]  pc, ac;
  logic [15:0] ir;
  logic        busy, halted, fault;

  accum_cpu_controller_if bus();

  accum_cpu_controller #(.ALU_SEL_ADD(4'b0001), .ALU_SEL_SUB(4'b0010)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
`ifdef ACCUM_CPU_SINGLE_STEP_EN
    .step       (step),
`endif
    .bus        (bus.master),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read (data next cycle) and synchronous write.
  logic [7:0] mem [256];
  logic [7:0] rdata_q = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_cs && bus.mem_oe) rdata_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  // ALU model
  assign bus.alu_out = (bus.alu_sel == 4'b0010) ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expected writes {addr,data}, expected read addresses.
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic        rd_chk_en = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_cs) acc_cnt++;
    if (bus.mem_cs && bus.mem_we) begin
      if (wr_q.size() == 0) chk("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 16'hxxxx);
      else                  chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, wr_q.pop_front());
    end
    if (rd_chk_en && bus.mem_cs && bus.mem_oe) begin
      if (rd_q.size() == 0) chk("unexpected_read", bus.mem_addr, 8'hxx);
      else                  chk("read_addr", bus.mem_addr, rd_q.pop_front());
    end
  end

  task automatic do_start(input logic [7:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts clock edges from the start edge up to the one that enters HALT.
  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 1;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  task automatic load2(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1);
    mem[a] = b0;
    mem[a + 8'd1] = b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acc0;
    logic seen;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_ac", ac, 8'h00);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_mem_ctl", {bus.mem_cs, bus.mem_we, bus.mem_oe}, 3'b000);
    chk("rst_status", {busy, halted, fault}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 1: LOAD/ADD/STORE/HALT
    load2(8'h00, 8'h10, 8'h20);
    load2(8'h02, 8'h30, 8'h21);
    load2(8'h04, 8'h20, 8'h22);
    load2(8'h06, 8'h70, 8'h00);
    mem[8'h20] = 8'h05; mem[8'h21] = 8'h07; mem[8'h22] = 8'h00;
    wr_q.push_back({8'h22, 8'h0C});
    do_start(8'h00);
    run_to_halt(200, cyc);
    chk("t1_cycles", cyc, 21 + 4 * STEP_EXTRA);
    chk("t1_ac", ac, 8'h0C);
    chk("t1_mem22", mem[8'h22], 8'h0C);
    chk("t1_pc", pc, 8'h08);
    chk("t1_fault", fault, 1'b0);
    chk("t1_wrq_empty", wr_q.size(), 0);

    // Test 3: PC wrap FE -> FF -> 00
    load2(8'hFE, 8'hA0, 8'h00);
    load2(8'h00, 8'h70, 8'h00);
    rd_q.push_back(8'hFE); rd_q.push_back(8'hFF);
    rd_q.push_back(8'h00); rd_q.push_back(8'h01);
    rd_chk_en = 1'b1;
    do_start(8'hFE);
    run_to_halt(200, cyc);
    rd_chk_en = 1'b0;
    chk("t3_cycles", cyc, 9 + 2 * STEP_EXTRA);
    chk("t3_rdq_empty", rd_q.size(), 0);
    chk("t3_ac", ac, 8'h00);
    chk("t3_pc", pc, 8'h02);

    // Test 2: 5*7 by repeated addition, loop closed with SUBT/SKIPCOND
    load2(8'h00, 8'h10, 8'h42);
    load2(8'h02, 8'h30, 8'h41);
    load2(8'h04, 8'h20, 8'h42);
    load2(8'h06, 8'h10, 8'h40);
    load2(8'h08, 8'h40, 8'h43);
    load2(8'h0A, 8'h20, 8'h40);
    load2(8'h0C, 8'h84, 8'h00);
    load2(8'h0E, 8'h90, 8'h00);
    load2(8'h10, 8'h70, 8'h00);
    mem[8'h40] = 8'h05; mem[8'h41] = 8'h07; mem[8'h42] = 8'h00; mem[8'h43] = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      wr_q.push_back({8'h42, 8'(7 * k)});
      wr_q.push_back({8'h40, 8'(5 - k)});
    end
    do_start(8'h00);
    run_to_halt(2000, cyc);
    chk("t2_result", mem[8'h42], 8'h23);
    chk("t2_count", mem[8'h40], 8'h00);
    chk("t2_fault", fault, 1'b0);
    chk("t2_pc", pc, 8'h12);
    chk("t2_wrq_empty", wr_q.size(), 0);

    // Signed SKIPCOND conditions and 8-bit add wrap
    load2(8'h50, 8'h10, 8'h60);
    load2(8'h52, 8'h80, 8'h00);
    load2(8'h54, 8'hA0, 8'h00);
    load2(8'h56, 8'h88, 8'h00);
    load2(8'h58, 8'h20, 8'h61);
    load2(8'h5A, 8'h8C, 8'h00);
    load2(8'h5C, 8'h30, 8'h62);
    load2(8'h5E, 8'h70, 8'h00);
    mem[8'h60] = 8'h80; mem[8'h61] = 8'h00; mem[8'h62] = 8'h90;
    wr_q.push_back({8'h61, 8'h80});
    do_start(8'h50);
    run_to_halt(300, cyc);
    chk("sk_mem61", mem[8'h61], 8'h80);
    chk("sk_ac_wrap", ac, 8'h10);
    chk("sk_pc", pc, 8'h60);
    chk("sk_wrq_empty", wr_q.size(), 0);

    // Test 4: illegal opcode
    load2(8'h00, 8'h50, 8'h00);
    load2(8'h70, 8'h70, 8'h00);
    do_start(8'h00);
    run_to_halt(100, cyc);
    chk("t4_cycles", cyc, 5 + STEP_EXTRA);
    chk("t4_fault", fault, 1'b1);
    chk("t4_pc", pc, 8'h02);
    do_start(8'h70);
    chk("t4_fault_cleared", fault, 1'b0);
    chk("t4_busy", busy, 1'b1);
    run_to_halt(100, cyc);
    chk("t4_fault_after", fault, 1'b0);

    // Test 5: reset while STORE is driving the write
    load2(8'h80, 8'h10, 8'h20);
    load2(8'h82, 8'h20, 8'h90);
    load2(8'h84, 8'h70, 8'h00);
    mem[8'h20] = 8'h05; mem[8'h90] = 8'h00;
    do_start(8'h80);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = bus.mem_we;
    end
    chk("t5_we_seen", seen, 1'b1);
    chk("t5_ac_before", ac, 8'h05);
    rst_n = 1'b0;
    #1;
    chk("t5_we_cs_drop", {bus.mem_we, bus.mem_cs}, 2'b00);
    chk("t5_pc_ac", {pc, ac}, 16'h0000);
    chk("t5_idle", {busy, halted}, 2'b00);
    @(posedge clk);
    #1;
    chk("t5_no_write", mem[8'h90], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wr_q.push_back({8'h90, 8'h05});
    do_start(8'h80);
    run_to_halt(200, cyc);
    chk("t5_rerun_mem90", mem[8'h90], 8'h05);
    chk("t5_wrq_empty", wr_q.size(), 0);

`ifdef ACCUM_CPU_SINGLE_STEP_EN
    // Test 6: single-step gating
    load2(8'hA0, 8'h10, 8'h20);
    load2(8'hA2, 8'h30, 8'h21);
    load2(8'hA4, 8'h70, 8'h00);
    mem[8'h21] = 8'h07;
    step = 1'b0;
    do_start(8'hA0);
    acc0 = acc_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_pc_frozen", pc, 8'hA0);
    chk("t6_no_access", acc_cnt - acc0, 0);
    chk("t6_busy", busy, 1'b1);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_pc_one", pc, 8'hA2);
    chk("t6_ac_one", ac, 8'h05);
    chk("t6_ir_one", ir, 16'h1020);
    chk("t6_accesses", acc_cnt - acc0, 3);
    step = 1'b1;
    run_to_halt(200, cyc);
    chk("t6_ac_final", ac, 8'h0C);
`else
    acc0 = acc_cnt;
    chk("idle_no_access", acc_cnt - acc0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
